mult_share_arb: RTL and testbench
=================================

Name: mult_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one 8x8 sequential multiplier (controller plus datapath) between NREQ requesters.
- Accepts operand pairs over per-requester req/gnt handshakes and issues a one-cycle start pulse to the multiplier.
- Holds operands stable until the multiplier's done pulse, then returns the 16-bit product tagged with the requester index over a valid/ready response port.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester index; must satisfy 2**IDW >= NREQ.
- TMO, 15, watchdog limit in cycles from start pulse to done (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset_a  in  1  asynchronous active-low reset.
- req  in  NREQ  request per requester; operands valid while high.
- dataa_in  in  NREQ*8  operand A per requester; requester i at bits [8i+7:8i].
- datab_in  in  NREQ*8  operand B per requester, same packing.
- gnt  out  NREQ  one-hot, one-cycle accept pulse; requester drops or changes req/operands after it.
- mult_start  out  1  start pulse to the multiplier controller.
- mult_dataa  out  8  operand A to the multiplier.
- mult_datab  out  8  operand B to the multiplier.
- mult_done  in  1  done pulse from the multiplier controller.
- mult_product  in  16  multiplier product, valid when mult_done=1.
- rsp_valid  out  1  response valid.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_product  out  16  captured product.
- rsp_err  out  1  response terminated by watchdog (tied 0 without the feature).
- rsp_ready  in  1  consumer accepts the response.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state IDLE, rr pointer 0, all outputs 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high, select the winner by round-robin starting at the rr pointer.
  - Latch its operands into mult_dataa/mult_datab and latch its index.
  - Pulse gnt[winner] for one cycle.
  - Set rr pointer to winner+1, wrapping NREQ-1 -> 0.
  - Go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE: mult_start=1 for exactly this one cycle; go to WAIT.
  - The start pulse is never longer than one cycle, because the controller errors if start is held.
- WAIT: mult_start=0; operands held constant.
  - On mult_done=1: capture mult_product into rsp_product, set rsp_valid=1, go to RESP.
  - mult_done is sampled only in WAIT and ignored in every other state.
- RESP: rsp_valid, rsp_id and rsp_product hold until rsp_ready=1.
  - On that cycle, clear rsp_valid and go to IDLE.
  - Arbitration restarts the following cycle, so a new grant occurs no earlier than one cycle after the handshake.
- Back-to-back: only one transaction is in flight; no request is granted while busy.
- Simultaneous requests: the rr pointer guarantees each active requester is served within NREQ transactions.
- req deasserted before its grant: the request is dropped; no grant is issued to it.
- Product width: 16 bits, unsigned, passed through unmodified.
- Grant-to-start latency: 1 cycle. Start-to-rsp_valid: the multiplier latency plus 1 cycle.
- Reset mid-operation: returns to IDLE with all outputs cleared; in-flight transaction lost; no response issued.

Optional Feature:
- Macro MULT_SHARE_ARB_WDOG_EN.
- Defined:
  - A cycle counter starts at ISSUE.
  - If mult_done is not seen within TMO cycles in WAIT, go to RESP with rsp_err=1 and rsp_product=0.
  - The next grant's start pulse also recovers the multiplier controller from its error state.
  - rsp_err clears with rsp_valid.
- Undefined: no counter, WAIT lasts indefinitely, rsp_err is constant 0.

Test Plan:
- req=4'b0001, A=8'hFF, B=8'hFF -> gnt=4'b0001 one cycle; mult_start one cycle later; after mult_done, rsp_product=16'hFE01, rsp_id=0.
- req=4'b1111 held; each requester i sends A=i+1, B=8'h10 -> grants in order 0,1,2,3,0; products 0x0010, 0x0020, 0x0030, 0x0040.
- rsp_ready held 0 for 5 cycles after rsp_valid -> outputs stable; no new gnt and no mult_start until the handshake.
- reset_a driven low during WAIT -> all outputs 0 immediately; after release, a pending req=4'b0100 is granted first.
- A=8'h00, B=8'h7B -> rsp_product=16'h0000; simultaneous req from requesters 1 and 3 with rr pointer=2 -> requester 3 granted first.
- With MULT_SHARE_ARB_WDOG_EN and mult_done forced 0 -> rsp_valid with rsp_err=1 and rsp_product=0 after TMO=15 cycles in WAIT.

Source files
------------

// File: rtl/mult_share_arb.sv
// Round-robin arbiter/sequencer sharing one 8x8 sequential multiplier between NREQ requesters.
// Optional watchdog on the multiplier done pulse: define MULT_SHARE_ARB_WDOG_EN.
module mult_share_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned TMO  = 15
) (
  input  logic              clk,
  input  logic              reset_a,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] dataa_in,
  input  logic [NREQ*8-1:0] datab_in,
  output logic [NREQ-1:0]   gnt,
  output logic              mult_start,
  output logic [7:0]        mult_dataa,
  output logic [7:0]        mult_datab,
  input  logic              mult_done,
  input  logic [15:0]       mult_product,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_product,
  output logic              rsp_err,
  input  logic              rsp_ready,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            start_q, start_d;
  logic [7:0]      a_q, a_d, b_q, b_d;
  logic            valid_q, valid_d;
  logic [15:0]     prod_q, prod_d;
  logic            err_q, err_d;
  logic            timeout;

  logic            found;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  idx;

  // First active requester at or after the rr pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(rr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

`ifdef MULT_SHARE_ARB_WDOG_EN
  localparam int unsigned CW = $clog2(TMO + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIssue) begin
      cnt_d = '0;
    end else if (state_q == StWait) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires on the TMO-th WAIT cycle without a done pulse.
  assign timeout = (state_q == StWait) && (cnt_q == CW'(TMO - 1));

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TMO;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    gnt_d   = '0;
    start_d = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    prod_d  = prod_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d   = NREQ'(1) << win;
          a_d     = dataa_in[8*win +: 8];
          b_d     = datab_in[8*win +: 8];
          id_d    = win;
          rr_d    = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Registered, so the start pulse lands exactly one cycle after the grant.
        start_d = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (mult_done) begin
          prod_d  = mult_product;
          valid_d = 1'b1;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timeout) begin
          prod_d  = '0;
          valid_d = 1'b1;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q <= StIdle;
      rr_q    <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end

  assign gnt         = gnt_q;
  assign mult_start  = start_q;
  assign mult_dataa  = a_q;
  assign mult_datab  = b_q;
  assign rsp_valid   = valid_q;
  assign rsp_id      = valid_q ? id_q : '0;
  assign rsp_product = prod_q;
  assign rsp_err     = err_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_mult_share_arb.sv
// Scoreboard bench for mult_share_arb: directed vectors, expected grants/responses queued by the
// stimulus and checked by an independent monitor on the falling clock edge.
module tb_mult_share_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TMO  = 15;
  localparam int LAT  = 3;

  logic              clk = 1'b0;
  logic              reset_a;
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] dataa_in, datab_in;
  logic [NREQ-1:0]   gnt;
  logic              mult_start;
  logic [7:0]        mult_dataa, mult_datab;
  logic              mult_done;
  logic [15:0]       mult_product;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_product;
  logic              rsp_err;
  logic              rsp_ready;
  logic              busy;

  mult_share_arb #(.NREQ(NREQ), .IDW(IDW), .TMO(TMO)) dut (
    .clk          (clk),
    .reset_a      (reset_a),
    .req          (req),
    .dataa_in     (dataa_in),
    .datab_in     (datab_in),
    .gnt          (gnt),
    .mult_start   (mult_start),
    .mult_dataa   (mult_dataa),
    .mult_datab   (mult_datab),
    .mult_done    (mult_done),
    .mult_product (mult_product),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_product  (rsp_product),
    .rsp_err      (rsp_err),
    .rsp_ready    (rsp_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Behavioural sequential multiplier: done pulse LAT cycles after start, or never when hung.
  logic        mul_hang;
  int          cd;
  logic [15:0] prod_m;
  always @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      cd           <= 0;
      mult_done    <= 1'b0;
      mult_product <= '0;
      prod_m       <= '0;
    end else begin
      mult_done <= 1'b0;
      if (mult_start) begin
        prod_m <= mult_dataa * mult_datab;
        cd     <= LAT;
      end else if (cd != 0) begin
        cd <= cd - 1;
        if (cd == 1 && !mul_hang) begin
          mult_done    <= 1'b1;
          mult_product <= prod_m;
        end
      end
    end
  end

  typedef struct packed {
    logic [NREQ-1:0] g;
    logic [7:0]      a;
    logic [7:0]      b;
  } gnt_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [15:0]    prod;
    logic           err;
  } rsp_t;

  gnt_t exp_gnt_q[$];
  rsp_t exp_rsp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: event not seen or unexpected (t=%0t)", name, $time);
  endtask

  task automatic exp_txn(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] prod, input logic err, input bit with_rsp);
    gnt_t g;
    rsp_t r;
    g.g  = NREQ'(1) << id;
    g.a  = a;
    g.b  = b;
    exp_gnt_q.push_back(g);
    r.id   = IDW'(id);
    r.prod = prod;
    r.err  = err;
    if (with_rsp) exp_rsp_q.push_back(r);
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    dataa_in[8*i +: 8] = a;
    datab_in[8*i +: 8] = b;
  endtask

  task automatic check_reset_outs(input string name);
    check(name, {gnt, mult_start, mult_dataa, mult_datab, rsp_valid, rsp_id, rsp_product,
                 rsp_err, busy}, 64'h0);
  endtask

  task automatic grants(input int n, input bit drop);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) begin
        seen++;
        if (drop) req = req & ~gnt;
      end
    end
    if (seen < n) flag("grant_timeout");
  endtask

  task automatic wait_idle();
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((exp_rsp_q.size() != 0 || exp_gnt_q.size() != 0 || busy) && cyc < 300);
    if (cyc >= 300) flag("idle_timeout");
  endtask

  task automatic wait_start();
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mult_start && cyc < 300);
    if (!mult_start) flag("start_timeout");
  endtask

  task automatic wait_valid();
    int cyc = 0;
    while (!rsp_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (!rsp_valid) flag("valid_timeout");
  endtask

  // Monitor: grant order/operands, start-after-grant, responses and backpressure.
  logic prev_gnt = 1'b0;
  logic prev_hs  = 1'b0;
  always @(negedge clk) begin
    gnt_t eg;
    if (!reset_a) begin
      prev_gnt = 1'b0;
      prev_hs  = 1'b0;
    end else begin
      if (gnt != '0) begin
        if (exp_gnt_q.size() == 0) begin
          flag("gnt_unexpected");
        end else begin
          eg = exp_gnt_q.pop_front();
          check("gnt", 64'(gnt), 64'(eg.g));
          check("operands", {mult_dataa, mult_datab}, {eg.a, eg.b});
        end
      end
      if (prev_gnt) check("start_after_gnt", 64'(mult_start), 64'd1);
      else if (mult_start) flag("start_without_gnt");
      if (prev_hs && gnt != '0) flag("gnt_right_after_handshake");
      if (rsp_valid) begin
        if (gnt != '0 || mult_start) flag("issue_while_resp");
        if (exp_rsp_q.size() == 0) begin
          flag("rsp_unexpected");
        end else begin
          check("rsp", {rsp_id, rsp_product, rsp_err},
                {exp_rsp_q[0].id, exp_rsp_q[0].prod, exp_rsp_q[0].err});
          if (rsp_ready) void'(exp_rsp_q.pop_front());
        end
      end
      prev_gnt = (gnt != '0);
      prev_hs  = rsp_valid && rsp_ready;
    end
  end

  initial begin
    reset_a   = 1'b0;
    req       = '0;
    dataa_in  = '0;
    datab_in  = '0;
    rsp_ready = 1'b1;
    mul_hang  = 1'b0;
    #1 check_reset_outs("reset_init");
    repeat (3) @(posedge clk);
    #1 reset_a = 1'b1;

    // Single requester, max operands.
    set_ops(0, 8'hFF, 8'hFF);
    exp_txn(0, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b1);
    req = 4'b0001;
    grants(1, 1'b1);
    wait_idle();

    // All four held after reset: order 0,1,2,3,0.
    @(posedge clk);
    #1 reset_a = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_a = 1'b1;
    set_ops(0, 8'h01, 8'h10);
    set_ops(1, 8'h02, 8'h10);
    set_ops(2, 8'h03, 8'h10);
    set_ops(3, 8'h04, 8'h10);
    exp_txn(0, 8'h01, 8'h10, 16'h0010, 1'b0, 1'b1);
    exp_txn(1, 8'h02, 8'h10, 16'h0020, 1'b0, 1'b1);
    exp_txn(2, 8'h03, 8'h10, 16'h0030, 1'b0, 1'b1);
    exp_txn(3, 8'h04, 8'h10, 16'h0040, 1'b0, 1'b1);
    exp_txn(0, 8'h01, 8'h10, 16'h0010, 1'b0, 1'b1);
    req = 4'b1111;
    grants(5, 1'b0);
    req = '0;
    wait_idle();

    // Backpressure with another requester pending (rr pointer is 1).
    set_ops(1, 8'h03, 8'h05);
    set_ops(0, 8'h02, 8'h02);
    exp_txn(1, 8'h03, 8'h05, 16'h000F, 1'b0, 1'b1);
    exp_txn(0, 8'h02, 8'h02, 16'h0004, 1'b0, 1'b1);
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    req = 4'b0011;
    grants(1, 1'b1);
    wait_valid();
    repeat (5) @(negedge clk);
    check("held_rsp_still_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    grants(1, 1'b1);
    wait_idle();

    // Reset during WAIT, request kept pending across it.
    set_ops(2, 8'h09, 8'h09);
    exp_txn(2, 8'h09, 8'h09, 16'h0051, 1'b0, 1'b0);
    req = 4'b0100;
    grants(1, 1'b0);
    wait_start();
    @(posedge clk);
    #1 reset_a = 1'b0;
    #1 check_reset_outs("reset_mid_wait");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_a = 1'b1;
    exp_txn(2, 8'h09, 8'h09, 16'h0051, 1'b0, 1'b1);
    grants(1, 1'b1);
    wait_idle();

    // Zero operand, then simultaneous 1 and 3 with rr pointer at 2.
    set_ops(1, 8'h00, 8'h7B);
    exp_txn(1, 8'h00, 8'h7B, 16'h0000, 1'b0, 1'b1);
    req = 4'b0010;
    grants(1, 1'b1);
    wait_idle();
    set_ops(3, 8'h0C, 8'h0D);
    set_ops(1, 8'hFF, 8'h02);
    exp_txn(3, 8'h0C, 8'h0D, 16'h009C, 1'b0, 1'b1);
    exp_txn(1, 8'hFF, 8'h02, 16'h01FE, 1'b0, 1'b1);
    req = 4'b1010;
    grants(2, 1'b1);
    wait_idle();

`ifdef MULT_SHARE_ARB_WDOG_EN
    // Hung multiplier: error response TMO cycles after the first WAIT cycle.
    mul_hang = 1'b1;
    set_ops(0, 8'h05, 8'h05);
    exp_txn(0, 8'h05, 8'h05, 16'h0000, 1'b1, 1'b1);
    req = 4'b0001;
    grants(1, 1'b1);
    wait_start();
    begin
      int k = 0;
      while (!rsp_valid && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("wdog_latency", 64'(k), 64'(TMO));
    end
    wait_idle();
    mul_hang = 1'b0;
    set_ops(0, 8'h06, 8'h07);
    exp_txn(0, 8'h06, 8'h07, 16'h002A, 1'b0, 1'b1);
    req = 4'b0001;
    grants(1, 1'b1);
    wait_idle();
`endif

    check("final_idle", {64'(busy), 64'(rsp_valid)}, 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
